// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath: fetch, decode, execute,
// memory and writeback sequencing with a mem_ready handshake on memory states.
module multicycle_main_control #(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_IEXEC  = 4'd9;
    localparam logic [3:0] S_IWB    = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [3:0] state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       illegal_q, illegal_d;
    logic       mem_rdy;

    assign mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                op_d = Op;
                case (Op)
                    OP_LW, OP_SW:                     state_d = S_MEMADR;
                    OP_RTYPE:                         state_d = (Funct == 6'b000000) ? S_FETCH : S_EXEC;
                    OP_BEQ:                           state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
                    OP_J:                             state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= 6'b000000;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    // Outputs are held at zero for the whole time rst_n is low, not just after the edge.
    always_comb begin
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALUOp      = 3'b000;
        illegal_op = 1'b0;
        state_o    = 4'd0;
        if (rst_n) begin
            illegal_op = illegal_q;
            state_o    = state_q;
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_rdy;
                    PCWrite = mem_rdy;
                end
                S_DECODE: ALUSrcB = 2'b11;
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 3'b010;
                end
                S_ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 3'b001;
                    PCSrc   = 2'b01;
                    Branch  = 1'b1;
                end
                S_IEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    case (op_q)
                        OP_ANDI: ALUOp = 3'b100;
                        OP_ORI:  ALUOp = 3'b110;
                        OP_SLTI: ALUOp = 3'b111;
                        default: ALUOp = 3'b000;
                    endcase
                end
                S_IWB:  RegWrite = 1'b1;
                S_JUMP: begin
                    PCSrc   = 2'b10;
                    PCWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
